// File: rtl/muldiv_sequencer_pkg.sv
// Shared core types for the iterative M-extension multiply/divide sequencer.
// Latency: n/a (types, constants and pure helper functions only).
// Backpressure: n/a.
package muldiv_sequencer_pkg;

    // Default operand/result width of the core
    localparam int CORE_XLEN = 32;

    // RISC-V M-extension funct3 encoding
    typedef enum logic [2:0] {
        OP_MUL    = 3'd0,
        OP_MULH   = 3'd1,
        OP_MULHSU = 3'd2,
        OP_MULHU  = 3'd3,
        OP_DIV    = 3'd4,
        OP_DIVU   = 3'd5,
        OP_REM    = 3'd6,
        OP_REMU   = 3'd7
    } muldiv_op_e;

    // Sequencer states
    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_PREP = 3'd1,
        ST_CALC = 3'd2,
        ST_FIX  = 3'd3,
        ST_DONE = 3'd4
    } muldiv_state_e;

    // Divide family (quotient or remainder)
    function automatic logic op_is_div(input muldiv_op_e o);
        return (o == OP_DIV) || (o == OP_DIVU) || (o == OP_REM) || (o == OP_REMU);
    endfunction

    // Remainder ops return the dividend-signed remainder
    function automatic logic op_is_rem(input muldiv_op_e o);
        return (o == OP_REM) || (o == OP_REMU);
    endfunction

    // rs1 is treated as two's complement
    function automatic logic op_a_signed(input muldiv_op_e o);
        return (o == OP_MUL) || (o == OP_MULH) || (o == OP_MULHSU) ||
               (o == OP_DIV) || (o == OP_REM);
    endfunction

    // rs2 is treated as two's complement
    function automatic logic op_b_signed(input muldiv_op_e o);
        return (o == OP_MUL) || (o == OP_MULH) || (o == OP_DIV) || (o == OP_REM);
    endfunction

endpackage

// File: rtl/muldiv_sequencer.sv
// Iterative multiply/divide unit: one shift-add or restoring-subtract step per cycle.
// Latency: done in cycle XLEN+3 after the start edge; div-by-zero/overflow in cycle 2.
// Backpressure: stall_req holds F/D/E until the op resolves; flush or rst abort with no done.
module muldiv_sequencer
    import muldiv_sequencer_pkg::*;
#(
    parameter int XLEN = CORE_XLEN
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic [2:0]      op,
    input  logic [XLEN-1:0] src_a,
    input  logic [XLEN-1:0] src_b,
    input  logic            flush,
    output logic            busy,
    output logic            stall_req,
    output logic            done,
    output logic [XLEN-1:0] result
);

    localparam int CW = $clog2(XLEN);
    localparam logic [XLEN-1:0] MIN_VAL = {1'b1, {(XLEN-1){1'b0}}};

    muldiv_state_e   state_q, state_d;
    muldiv_op_e      op_q, op_d;
    logic [XLEN-1:0] a_q, a_d;
    logic [XLEN-1:0] b_q, b_d;
    // hi:lo is the product during multiply, remainder:quotient during divide
    logic [XLEN-1:0] hi_q, hi_d;
    logic [XLEN-1:0] lo_q, lo_d;
    // multiplicand or divisor magnitude
    logic [XLEN-1:0] opnd_q, opnd_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic            neg_q, neg_d;
    logic [XLEN-1:0] result_q, result_d;

    logic            sign_a, sign_b;
    logic [XLEN-1:0] mag_a, mag_b;
    logic            div_ovf;
    logic [XLEN:0]   mul_sum;
    logic [XLEN:0]   div_shift, div_diff;
    logic [2*XLEN-1:0] prod_neg;

    // Operand magnitudes and per-step datapath arithmetic
    assign sign_a    = op_a_signed(op_q) & a_q[XLEN-1];
    assign sign_b    = op_b_signed(op_q) & b_q[XLEN-1];
    assign mag_a     = sign_a ? -a_q : a_q;
    assign mag_b     = sign_b ? -b_q : b_q;
    assign div_ovf   = ((op_q == OP_DIV) || (op_q == OP_REM)) &&
                       (a_q == MIN_VAL) && (b_q == {XLEN{1'b1}});
    assign mul_sum   = {1'b0, hi_q} + (lo_q[0] ? {1'b0, opnd_q} : {(XLEN+1){1'b0}});
    assign div_shift = {hi_q, lo_q[XLEN-1]};
    assign div_diff  = div_shift - {1'b0, opnd_q};
    assign prod_neg  = -{hi_q, lo_q};

    assign busy   = (state_q != ST_IDLE);
    assign done   = (state_q == ST_DONE);
    assign result = result_q;

    // Next-state, datapath step and stall request
    always_comb begin
        state_d   = state_q;
        op_d      = op_q;
        a_d       = a_q;
        b_d       = b_q;
        hi_d      = hi_q;
        lo_d      = lo_q;
        opnd_d    = opnd_q;
        cnt_d     = cnt_q;
        neg_d     = neg_q;
        result_d  = result_q;
        stall_req = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (start && !flush) begin
                    stall_req = 1'b1;
                    op_d      = muldiv_op_e'(op);
                    a_d       = src_a;
                    b_d       = src_b;
                    state_d   = ST_PREP;
                end
            end
            ST_PREP: begin
                stall_req = 1'b1;
                if (flush) begin
                    state_d = ST_IDLE;
                end else if (op_is_div(op_q) && (b_q == '0)) begin
                    // Divide by zero: all-ones quotient, dividend as remainder
                    result_d = op_is_rem(op_q) ? a_q : {XLEN{1'b1}};
                    state_d  = ST_DONE;
                end else if (div_ovf) begin
                    result_d = (op_q == OP_REM) ? '0 : MIN_VAL;
                    state_d  = ST_DONE;
                end else begin
                    hi_d    = '0;
                    lo_d    = mag_a;
                    opnd_d  = mag_b;
                    cnt_d   = CW'(XLEN - 1);
                    // Remainder takes the dividend's sign; everything else the xor
                    neg_d   = op_is_rem(op_q) ? sign_a : (sign_a ^ sign_b);
                    state_d = ST_CALC;
                end
            end
            ST_CALC: begin
                stall_req = 1'b1;
                if (flush) begin
                    state_d = ST_IDLE;
                end else begin
                    if (op_is_div(op_q)) begin
                        // Restoring step: keep the subtraction only when it did not borrow
                        if (!div_diff[XLEN]) begin
                            hi_d = div_diff[XLEN-1:0];
                            lo_d = {lo_q[XLEN-2:0], 1'b1};
                        end else begin
                            hi_d = div_shift[XLEN-1:0];
                            lo_d = {lo_q[XLEN-2:0], 1'b0};
                        end
                    end else begin
                        // Shift-add step: product shifts right as multiplier bits retire
                        hi_d = mul_sum[XLEN:1];
                        lo_d = {mul_sum[0], lo_q[XLEN-1:1]};
                    end
                    if (cnt_q == '0) begin
                        state_d = ST_FIX;
                    end else begin
                        cnt_d = cnt_q - 1'b1;
                    end
                end
            end
            ST_FIX: begin
                stall_req = 1'b1;
                if (flush) begin
                    state_d = ST_IDLE;
                end else begin
                    case (op_q)
                        OP_MUL:                       result_d = neg_q ? prod_neg[XLEN-1:0] : lo_q;
                        OP_MULH, OP_MULHSU, OP_MULHU: result_d = neg_q ? prod_neg[2*XLEN-1:XLEN] : hi_q;
                        OP_DIV, OP_DIVU:              result_d = neg_q ? -lo_q : lo_q;
                        default:                      result_d = neg_q ? -hi_q : hi_q;
                    endcase
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // All sequencer and datapath registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            op_q     <= OP_MUL;
            a_q      <= '0;
            b_q      <= '0;
            hi_q     <= '0;
            lo_q     <= '0;
            opnd_q   <= '0;
            cnt_q    <= '0;
            neg_q    <= 1'b0;
            result_q <= '0;
        end else begin
            state_q  <= state_d;
            op_q     <= op_d;
            a_q      <= a_d;
            b_q      <= b_d;
            hi_q     <= hi_d;
            lo_q     <= lo_d;
            opnd_q   <= opnd_d;
            cnt_q    <= cnt_d;
            neg_q    <= neg_d;
            result_q <= result_d;
        end
    end

endmodule

// File: tb/tb_muldiv_sequencer.sv
// Bench for muldiv_sequencer: directed ops with literal results plus a cycle-level reference.
// Latency: reference expects done at cycle 35 (normal) or cycle 2 (div-by-zero/overflow).
// Backpressure: checks stall_req/busy every cycle, including flush and async reset aborts.
module tb_muldiv_sequencer;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic [2:0]  op = 3'd0;
    logic [31:0] src_a = '0;
    logic [31:0] src_b = '0;
    logic        flush = 1'b0;
    logic        busy, stall_req, done;
    logic [31:0] result;

    int checks = 0;
    int failures = 0;
    logic [31:0] last_lit = '0;

    muldiv_sequencer dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .op        (op),
        .src_a     (src_a),
        .src_b     (src_b),
        .flush     (flush),
        .busy      (busy),
        .stall_req (stall_req),
        .done      (done),
        .result    (result)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    // Architectural result of an M-extension op
    function automatic logic [31:0] ref_result(input logic [2:0] o, input logic [31:0] a,
                                               input logic [31:0] b);
        int          sa, sb;
        longint      ps;
        logic [63:0] p;
        sa = a;
        sb = b;
        case (o)
            3'd0: begin ps = longint'(sa) * longint'(sb); p = ps; return p[31:0]; end
            3'd1: begin ps = longint'(sa) * longint'(sb); p = ps; return p[63:32]; end
            3'd2: begin ps = longint'(sa) * longint'({32'b0, b}); p = ps; return p[63:32]; end
            3'd3: begin p = {32'b0, a} * {32'b0, b}; return p[63:32]; end
            3'd4: begin
                if (b == 0) return 32'hFFFF_FFFF;
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h8000_0000;
                return sa / sb;
            end
            3'd5: return (b == 0) ? 32'hFFFF_FFFF : a / b;
            3'd6: begin
                if (b == 0) return a;
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h0;
                return sa % sb;
            end
            default: return (b == 0) ? a : a % b;
        endcase
    endfunction

    function automatic int ref_latency(input logic [2:0] o, input logic [31:0] a,
                                       input logic [31:0] b);
        if (o >= 3'd4 && b == 0) return 2;
        if ((o == 3'd4 || o == 3'd6) && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 2;
        return 35;
    endfunction

    // Reference: cycle index since accepted start (-1 when idle), checked every cycle
    int          m_cyc = -1;
    int          m_lat = 0;
    logic [31:0] m_exp = '0;
    logic [31:0] m_prev = '0;

    always @(negedge clk) begin
        if (rst) begin
            chk("rst_busy", {31'b0, busy}, 32'd0);
            chk("rst_done", {31'b0, done}, 32'd0);
            chk("rst_stall", {31'b0, stall_req}, 32'd0);
            chk("rst_result", result, 32'd0);
            m_cyc  = -1;
            m_prev = '0;
        end else begin
            if (m_cyc < 0 && start && !flush) begin
                m_cyc = 0;
                m_exp = ref_result(op, src_a, src_b);
                m_lat = ref_latency(op, src_a, src_b);
            end
            if (m_cyc < 0) begin
                chk("idle_busy", {31'b0, busy}, 32'd0);
                chk("idle_done", {31'b0, done}, 32'd0);
                chk("idle_stall", {31'b0, stall_req}, 32'd0);
                chk("idle_result", result, m_prev);
            end else begin
                chk("cyc_stall", {31'b0, stall_req}, {31'b0, (m_cyc < m_lat)});
                chk("cyc_busy", {31'b0, busy}, {31'b0, (m_cyc >= 1)});
                chk("cyc_done", {31'b0, done}, {31'b0, (m_cyc == m_lat)});
                chk("cyc_result", result, (m_cyc == m_lat) ? m_exp : m_prev);
                if (m_cyc == m_lat) begin
                    m_prev = m_exp;
                    m_cyc  = -1;
                end else if (flush && m_cyc >= 1) begin
                    m_cyc = -1;
                end else begin
                    m_cyc++;
                end
            end
        end
    end

    // Present an op for one cycle; returns at posedge+1 of cycle 1
    task automatic issue(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
        start = 1'b1;
        op    = o;
        src_a = a;
        src_b = b;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    // Run one op to completion; entered and left at posedge+1 of an idle cycle
    task automatic do_op(input string name, input logic [2:0] o, input logic [31:0] a,
                         input logic [31:0] b, input logic [31:0] lit, input int lat_lit,
                         input bit noise, input bit start_in_done);
        int n;
        issue(o, a, b);
        n = 1;
        while (!done && n < 60) begin
            @(posedge clk); #1;
            n++;
            if (noise) begin
                start = (n == 5);
                op    = 3'd0;
                src_a = 32'd1;
                src_b = 32'd1;
            end
        end
        start = 1'b0;
        if (!done) begin
            checks++;
            failures++;
            $display("FAIL %s_timeout: no done within %0d cycles", name, n);
        end else begin
            chk({name, "_latency"}, n, lat_lit);
            chk({name, "_result"}, result, lit);
        end
        last_lit = lit;
        if (start_in_done) begin
            start = 1'b1;
            op    = 3'd0;
            src_a = 32'd9;
            src_b = 32'd9;
        end
        @(posedge clk); #1;
        start = 1'b0;
        if (start_in_done) chk({name, "_done_start_ignored"}, {31'b0, busy}, 32'd0);
    endtask

    initial begin : watchdog
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin : stim
        int  n;
        bit  seen;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;

        do_op("mul_7_m3",    3'd0, 32'd7,          32'hFFFF_FFFD, 32'hFFFF_FFEB, 35, 0, 0);
        do_op("mulhu_ones",  3'd3, 32'hFFFF_FFFF,  32'hFFFF_FFFF, 32'hFFFF_FFFE, 35, 0, 0);
        do_op("mulh_ones",   3'd1, 32'hFFFF_FFFF,  32'hFFFF_FFFF, 32'h0000_0000, 35, 1, 0);
        do_op("div_m7_2",    3'd4, 32'hFFFF_FFF9,  32'd2,         32'hFFFF_FFFD, 35, 0, 1);
        do_op("rem_m7_2",    3'd6, 32'hFFFF_FFF9,  32'd2,         32'hFFFF_FFFF, 35, 0, 0);
        do_op("divu_5_0",    3'd5, 32'd5,          32'd0,         32'hFFFF_FFFF, 2,  0, 0);
        do_op("div_ovf",     3'd4, 32'h8000_0000,  32'hFFFF_FFFF, 32'h8000_0000, 2,  0, 0);
        do_op("rem_ovf",     3'd6, 32'h8000_0000,  32'hFFFF_FFFF, 32'h0000_0000, 2,  0, 1);
        do_op("remu_5_0",    3'd7, 32'd5,          32'd0,         32'd5,         2,  0, 0);
        do_op("mulhsu_m1_2", 3'd2, 32'hFFFF_FFFF,  32'd2,         32'hFFFF_FFFF, 35, 0, 0);
        do_op("mulh_min",    3'd1, 32'h8000_0000,  32'h8000_0000, 32'h4000_0000, 35, 0, 0);
        do_op("divu_100_7",  3'd5, 32'd100,        32'd7,         32'd14,        35, 1, 0);
        do_op("remu_100_7",  3'd7, 32'd100,        32'd7,         32'd2,         35, 0, 0);
        do_op("div_7_m2",    3'd4, 32'd7,          32'hFFFF_FFFE, 32'hFFFF_FFFD, 35, 0, 0);
        do_op("rem_7_m2",    3'd6, 32'd7,          32'hFFFF_FFFE, 32'd1,         35, 0, 0);
        do_op("mul_low",     3'd0, 32'h1234_5678,  32'h10,        32'h2345_6780, 35, 0, 0);

        // Flush at cycle 10 of a divide
        issue(3'd4, 32'd100, 32'd3);
        n = 1;
        while (n < 10) begin @(posedge clk); #1; n++; end
        flush = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0;
        chk("flush_busy", {31'b0, busy}, 32'd0);
        chk("flush_stall", {31'b0, stall_req}, 32'd0);
        chk("flush_result", result, last_lit);
        seen = 0;
        repeat (40) begin
            @(posedge clk); #1;
            if (done) seen = 1;
        end
        chk("flush_no_done", {31'b0, seen}, 32'd0);

        // Start with flush in idle is dropped
        start = 1'b1; flush = 1'b1; op = 3'd0; src_a = 32'd2; src_b = 32'd2;
        @(posedge clk); #1;
        start = 1'b0; flush = 1'b0;
        chk("start_flush_idle", {31'b0, busy}, 32'd0);

        // Asynchronous reset during CALC
        issue(3'd0, 32'd5, 32'd6);
        n = 1;
        while (n < 15) begin @(posedge clk); #1; n++; end
        rst = 1'b1;
        #1;
        chk("arst_busy", {31'b0, busy}, 32'd0);
        chk("arst_done", {31'b0, done}, 32'd0);
        chk("arst_result", result, 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        do_op("mul_3_4_after_rst", 3'd0, 32'd3, 32'd4, 32'd12, 35, 0, 0);

        repeat (2) @(posedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
